polar_clip_mul_arbiter: RTL
===========================

// Module: polar_clip_mul_arbiter
// PURPOSE
//   Shares one pipelined 16x16 signed multiplier (4-cycle latency, ce-gated) among NUM_REQ requesters.
//   - Round-robin arbitration; at most one issue per cycle.
//   - Tracks in-flight operations with a valid/ID sideband pipeline.
//   - Returns each product on a single tagged result stream.
//   - Downstream backpressure freezes the whole pipeline through the multiplier's ce.
// PARAMETERS
//   NUM_REQ  4   number of requesters, 2..8
//   ID_W     2   requester ID width, >= clog2(NUM_REQ)
//   DATA_W  16   operand and product width (fixed at 16; checked at elaboration)
// PORTS
//   clk        in   1              single clock, all logic on the rising edge
//   reset_n    in   1              asynchronous, active-low reset
//   req_valid  in   NUM_REQ        per-requester operation valid
//   req_ready  out  NUM_REQ        per-requester accept; at most one bit high
//   req_a      in   NUM_REQ*16     operand a, requester i at [16i+15:16i], signed
//   req_b      in   NUM_REQ*16     operand b, same packing, signed
//   res_valid  out  1              result valid
//   res_ready  in   1              result accept from downstream
//   res_id     out  ID_W           index of the requester that issued this result
//   res_p      out  16             low 16 bits of the signed product a*b
//   busy       out  1              any operation in flight or result pending
// BEHAVIOUR
//   - Reset: everything is cleared and all in-flight work is discarded.
//     - res_valid=0, res_id=0, res_p=0, busy=0, req_ready=0.
//     - Round-robin pointer set so requester 0 has top priority.
//     - Asserting reset mid-operation produces no res_valid after release.
//   - Stall: ce = ~(res_valid & ~res_ready).
//     - While ce=0: req_ready=0, and the multiplier, valid/ID pipe and output register all hold.
//     - Bubbles are not compressed.
//   - Arbitration:
//     - grant = first requester with req_valid high, searching upward from (last_grant+1) mod NUM_REQ.
//     - req_ready[i] = ce & grant[i]. It is combinational from req_valid; requesters must not make req_valid depend on req_ready.
//     - last_grant updates only on an accepted handshake (req_valid[i] & req_ready[i]).
//   - Requester rule: hold req_valid, req_a and req_b stable until accepted. Dropping valid early is illegal (bench asserts).
//   - Issue: the accepted operands are muxed into the multiplier din0/din1. When idle, zero operands with valid=0 are injected.
//   - Latency:
//     - Handshake at edge k -> res_valid=1 after edge k+4, when no stall occurs.
//     - Each ce=0 cycle adds one cycle of latency.
//   - Throughput: one result per cycle when res_ready=1.
//   - Output:
//     - res_valid/res_id/res_p are registered.
//     - They hold stable while res_valid & ~res_ready.
//     - They clear (or load the next op) on res_ready.
//   - Arithmetic: res_p = (a*b)[15:0]; wrap, no saturation.
//     - 0x7FFF*0x7FFF -> 0x0001
//     - 0x8000*0xFFFF -> 0x8000
//   - Simultaneous events:
//     - All requesters valid: grants rotate 0,1,..,NUM_REQ-1,0.
//     - A new issue and a result pop in the same cycle are both legal.
//   - busy = |valid_pipe | res_valid.
// CONFIGURATION
//   - Macro POLAR_CLIP_MUL_ARB_PERF_EN.
//   - Defined: adds the following ports, all counters reset to 0:
//     - perf_clr in 1: synchronous clear, wins over increments.
//     - perf_issue_cnt out 32: +1 per accepted request.
//     - perf_stall_cnt out 32: +1 per cycle with ce=0.
//     - Counters wrap at 2^32.
//   - Undefined: no ports, no counter logic; functionally identical otherwise.
// STRUCTURE
//   - Package polar_clip_mul_arb_pkg:
//     - MUL_LAT=4, DATA_W=16.
//     - typedef logic signed [15:0] operand_t.
//     - function rr_pick(valid, last) returning a one-hot grant.
//   - Sub-module polar_clip_mul_arb_pipe:
//     - 16x16 signed multiply, 4 registered stages, all gated by ce.
//     - Carries valid and ID sideband registers of equal depth.
//   - Top level contains only the arbiter, operand mux, output register and optional counters.
// TESTING
//   - Reset/idle: reset_n low 3 cycles, no req_valid -> res_valid=0, busy=0, req_ready=0 throughout.
//   - Single stream, latency and throughput:
//     - Stimulus: req0 issues a=3,b=-5 at edge k, then a=0x7FFF,b=0x7FFF at k+1, res_ready=1.
//     - Required: res_p=0xFFF1,id=0 after k+4; res_p=0x0001 after k+5.
//   - Fairness: all 4 req_valid high for 8 issues -> res_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
//   - Backpressure:
//     - Stimulus: res_ready=0 for 5 cycles while res_valid=1.
//     - Required: res_p/res_id stable, req_ready=0, no result lost or duplicated.
//     - Under POLAR_CLIP_MUL_ARB_PERF_EN: perf_stall_cnt=5.
//   - Reset mid-flight: 3 ops in flight, pulse reset_n low 1 cycle -> no res_valid afterwards, grant restarts at requester 0.
//   - Random: constrained-random operands and valids vs. reference model.
//     - Checks: products, per-requester ordering, no starvation (wait <= NUM_REQ accepts).

Source files
------------

// File: rtl/polar_clip_mul_arb_pkg.sv
// polar_clip_mul_arb_pkg
//   Shared types, constants and the round-robin pick function used by the
//   polar_clip_mul_arbiter slice.
//   MUL_LAT  : register stages inside the shared multiplier
//   DATA_W   : operand / product width (16)
//   MAX_REQ  : widest requester vector rr_pick handles
//   operand_t: signed 16-bit operand
//   rr_pick  : one-hot grant, searching upward from (last+1) mod n
`timescale 1ns/1ps
package polar_clip_mul_arb_pkg;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAX_REQ = 8;

  typedef logic signed [DATA_W-1:0] operand_t;

  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                 input logic [2:0]         last,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] grant;
    logic [2:0]         idx;
    grant = '0;
    for (int unsigned k = 1; k <= MAX_REQ; k++) begin
      idx = 3'((32'(last) + k) % n);
      if (k <= n && grant == '0 && valid[idx]) grant[idx] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/polar_clip_mul_arbiter_if.sv
// polar_clip_mul_arbiter_if
//   Request/result bus of the shared multiplier arbiter.
//   req_valid/req_ready : per-requester handshake (NUM_REQ bits)
//   req_a/req_b         : packed signed operands, requester i at [16i+15:16i]
//   res_valid/res_ready : tagged result stream handshake
//   res_id/res_p        : issuing requester index and low 16 product bits
//   master = requesters + result consumer, slave = arbiter
`timescale 1ns/1ps
interface polar_clip_mul_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  import polar_clip_mul_arb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic                      res_valid;
  logic                      res_ready;
  logic [ID_W-1:0]           res_id;
  logic [DATA_W-1:0]         res_p;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_id, res_p
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_id, res_p
  );

endinterface

// File: rtl/polar_clip_mul_arb_pipe.sv
// polar_clip_mul_arb_pipe
//   4-stage pipelined 16x16 signed multiplier with matching valid/ID sideband.
//   All stages advance only when ce is high.
//   in_valid/in_id/in_a/in_b : issue slot (zeros with valid=0 when idle)
//   out_valid/out_id/out_p   : last stage contents
//   any_valid                : any stage holds a live operation
`timescale 1ns/1ps
module polar_clip_mul_arb_pipe
  import polar_clip_mul_arb_pkg::*;
#(
  parameter int unsigned ID_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              ce,
  input  logic              in_valid,
  input  logic [ID_W-1:0]   in_id,
  input  operand_t          in_a,
  input  operand_t          in_b,
  output logic              out_valid,
  output logic [ID_W-1:0]   out_id,
  output logic [DATA_W-1:0] out_p,
  output logic              any_valid
);

  operand_t          a_q, b_q;
  logic [DATA_W-1:0] prod_lo, p2_q, p3_q, p4_q;
  logic [MUL_LAT-1:0] v_q;
  logic [ID_W-1:0]   id_q [MUL_LAT];

  // The low half of a two's-complement product is independent of operand
  // signedness, so a 16-bit-wide multiply yields the wrapped result directly.
  assign prod_lo = a_q * b_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      p2_q <= '0;
      p3_q <= '0;
      p4_q <= '0;
      v_q  <= '0;
      for (int unsigned s = 0; s < MUL_LAT; s++) id_q[s] <= '0;
    end else if (ce) begin
      a_q     <= in_a;
      b_q     <= in_b;
      p2_q    <= prod_lo;
      p3_q    <= p2_q;
      p4_q    <= p3_q;
      v_q     <= {v_q[MUL_LAT-2:0], in_valid};
      id_q[0] <= in_id;
      for (int unsigned s = 1; s < MUL_LAT; s++) id_q[s] <= id_q[s-1];
    end
  end

  assign out_valid = v_q[MUL_LAT-1];
  assign out_id    = id_q[MUL_LAT-1];
  assign out_p     = p4_q;
  assign any_valid = |v_q;

endmodule

// File: rtl/polar_clip_mul_arbiter.sv
// polar_clip_mul_arbiter
//   Round-robin arbiter sharing one pipelined signed multiplier among
//   NUM_REQ requesters; results return tagged with the requester index.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : polar_clip_mul_arbiter_if.slave (request and result streams)
//   busy         : operation in flight or result pending
//   Optional (macro POLAR_CLIP_MUL_ARB_PERF_EN):
//     perf_clr       : synchronous clear of both counters
//     perf_issue_cnt : accepted requests
//     perf_stall_cnt : cycles with the pipeline frozen
`timescale 1ns/1ps
module polar_clip_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  polar_clip_mul_arbiter_if.slave       bus,
  output logic                          busy
`ifdef POLAR_CLIP_MUL_ARB_PERF_EN
  ,
  input  logic                          perf_clr,
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_stall_cnt
`endif
);
  import polar_clip_mul_arb_pkg::*;

  if (DATA_W != 16) begin : g_bad_data_w
    $error("polar_clip_mul_arbiter: DATA_W must be 16");
  end
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || (32'd1 << ID_W) < NUM_REQ) begin : g_bad_num_req
    $error("polar_clip_mul_arbiter: NUM_REQ must be 2..8 and fit in ID_W");
  end

  logic               ce, issue;
  logic [MAX_REQ-1:0] pick;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    last_grant, gid;
  operand_t           din_a, din_b;
  logic               p_valid, p_any;
  logic [ID_W-1:0]    p_id;
  logic [DATA_W-1:0]  p_prod;
  logic               res_valid_q;
  logic [ID_W-1:0]    res_id_q;
  logic [DATA_W-1:0]  res_p_q;
  logic               unused_pick;

  // A held result that is not being taken freezes every stage.
  assign ce = ~(res_valid_q & ~bus.res_ready);

  always_comb pick = rr_pick(MAX_REQ'(bus.req_valid), 3'(last_grant), NUM_REQ);
  assign grant       = pick[NUM_REQ-1:0];
  assign unused_pick = ^pick;

  assign bus.req_ready = ce ? grant : '0;
  assign issue         = ce & (|grant);

  // Grant is one-hot or zero, so the mux falls back to zero operands / ID 0.
  always_comb begin
    gid   = '0;
    din_a = '0;
    din_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gid   = ID_W'(i);
        din_a = bus.req_a[i*DATA_W +: DATA_W];
        din_b = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   last_grant <= ID_W'(NUM_REQ - 1);
    else if (issue) last_grant <= gid;
  end

  polar_clip_mul_arb_pipe #(.ID_W(ID_W)) u_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .ce        (ce),
    .in_valid  (issue),
    .in_id     (gid),
    .in_a      (din_a),
    .in_b      (din_b),
    .out_valid (p_valid),
    .out_id    (p_id),
    .out_p     (p_prod),
    .any_valid (p_any)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_p_q     <= '0;
    end else if (ce) begin
      res_valid_q <= p_valid;
      res_id_q    <= p_id;
      res_p_q     <= p_prod;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_p     = res_p_q;
  assign busy          = p_any | res_valid_q;

`ifdef POLAR_CLIP_MUL_ARB_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_issue_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (issue) perf_issue_cnt <= perf_issue_cnt + 32'd1;
      if (!ce)   perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
